// File: rtl/spi_pkg.sv
// SPI memory link shared definitions: frame geometry, command encoding, FSM states.
// Latency: n/a (constants only).
// Backpressure: n/a.
package spi_pkg;

    localparam int SPI_ADDR_W     = 7;
    localparam int SPI_DATA_W     = 8;
    localparam int SPI_FRAME_BITS = 16;

    // Command byte LSB: 1 selects a read, 0 a write.
    localparam logic RW_READ = 1'b1;

    // State codes are fixed so the slave FSM decodes the same values.
    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_SETUP = 3'd1;
    localparam logic [2:0] ST_SHIFT = 3'd2;
    localparam logic [2:0] ST_HOLD  = 3'd3;
    localparam logic [2:0] ST_DONE  = 3'd4;

    typedef enum logic [2:0] {
        IDLE  = ST_IDLE,
        SETUP = ST_SETUP,
        SHIFT = ST_SHIFT,
        HOLD  = ST_HOLD,
        DONE  = ST_DONE
    } spi_state_t;

endpackage

// File: rtl/spi_master_if.sv
// Host request/response bus plus SPI pins of the SPI memory initiator.
// Latency: n/a (wires only).
// Backpressure: host must hold off start while busy is high; extra starts are dropped.
interface spi_master_if;
    import spi_pkg::*;

    logic                  start;
    logic                  rw;
    logic [SPI_ADDR_W-1:0] addr;
    logic [SPI_DATA_W-1:0] wdata;
    logic                  busy;
    logic                  done;
    logic [SPI_DATA_W-1:0] rdata;
    logic                  sclk;
    logic                  cs_n;
    logic                  mosi;
    logic                  miso;

    // Initiator view.
    modport master (
        input  start, rw, addr, wdata, miso,
        output busy, done, rdata, sclk, cs_n, mosi
    );

    // Host plus memory-side view.
    modport slave (
        output start, rw, addr, wdata, miso,
        input  busy, done, rdata, sclk, cs_n, mosi
    );

endinterface

// File: rtl/spi_tick_gen.sv
// Half-period timebase: one-cycle tick every HALF clocks while enabled.
// Latency: first tick HALF cycles after enable rises; counter clears when disabled.
// Backpressure: none; free-running while enabled.
module spi_tick_gen #(
    parameter int HALF = 8
) (
    input  logic clk,
    input  logic reset_n,
    input  logic enable,
    output logic tick
);

    localparam int             CW   = (HALF > 1) ? $clog2(HALF) : 1;
    localparam logic [CW-1:0]  TERM = CW'(HALF - 1);

    logic [CW-1:0] cnt;

    // Count 0..HALF-1 and reload; parked at zero whenever the link is idle.
    always_ff @(posedge clk) begin
        if (!reset_n || !enable) begin
            cnt <= '0;
        end else if (cnt == TERM) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + CW'(1);
        end
    end

    assign tick = enable && (cnt == TERM);

endmodule

// File: rtl/spi_master.sv
// SPI mode-0 initiator: one {addr,rw} command byte plus one data byte per request.
// Latency: cs_n low for 34*HALF cycles from the cycle after start; done on the first cs_n-high cycle.
// Backpressure: start honoured only in IDLE (busy=0); starts while busy are dropped, no queueing.
module spi_master
    import spi_pkg::*;
#(
    parameter int HALF = 8
) (
    input  logic         clk,
    input  logic         reset_n,
    spi_master_if.master bus
);

    // The slave's input conditioner needs at least four cycles per sclk phase.
    if (HALF < 4) begin : g_half_check
        $error("spi_master: HALF must be 4 or more");
    end

    spi_state_t                state;
    logic [SPI_FRAME_BITS-1:0] tx;
    logic [SPI_FRAME_BITS-1:0] frame;
    logic [SPI_DATA_W-1:0]     rx;
    logic [SPI_DATA_W-1:0]     rdata_q;
    logic [3:0]                bit_cnt;
    logic                      last_bit;
    logic                      rw_q;
    logic                      sclk_q;
    logic                      cs_n_q;
    logic                      mosi_q;
    logic                      busy_q;
    logic                      done_q;
    logic                      tick_en;
    logic                      tick;

    // Reads clock out a zero data byte; the slave drives miso during it.
    assign frame = {bus.addr, bus.rw, (bus.rw == RW_READ) ? {SPI_DATA_W{1'b0}} : bus.wdata};

    assign tick_en = (state == SETUP) || (state == SHIFT) || (state == HOLD);

    spi_tick_gen #(.HALF(HALF)) u_tick (
        .clk     (clk),
        .reset_n (reset_n),
        .enable  (tick_en),
        .tick    (tick)
    );

    // Frame sequencer; every pin and status output is a flop driven from here.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state    <= IDLE;
            tx       <= '0;
            rx       <= '0;
            rdata_q  <= '0;
            bit_cnt  <= '0;
            last_bit <= 1'b0;
            rw_q     <= 1'b0;
            sclk_q   <= 1'b0;
            cs_n_q   <= 1'b1;
            mosi_q   <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        tx       <= frame;
                        rw_q     <= bus.rw;
                        rx       <= '0;
                        bit_cnt  <= '0;
                        last_bit <= 1'b0;
                        cs_n_q   <= 1'b0;
                        mosi_q   <= frame[SPI_FRAME_BITS-1];
                        busy_q   <= 1'b1;
                        state    <= SETUP;
                    end
                end
                SETUP: begin
                    // Leaving SETUP is the first sclk rise of the frame.
                    if (tick) begin
                        sclk_q <= 1'b1;
                        rx     <= {rx[SPI_DATA_W-2:0], bus.miso};
                        state  <= SHIFT;
                    end
                end
                SHIFT: begin
                    if (tick) begin
                        if (sclk_q) begin
                            // Falling edge: advance mosi, or park it low after bit 15.
                            sclk_q <= 1'b0;
                            tx     <= {tx[SPI_FRAME_BITS-2:0], 1'b0};
                            if (bit_cnt == 4'd15) begin
                                last_bit <= 1'b1;
                                mosi_q   <= 1'b0;
                            end else begin
                                bit_cnt <= bit_cnt + 4'd1;
                                mosi_q  <= tx[SPI_FRAME_BITS-2];
                            end
                        end else if (last_bit) begin
                            // Low phase of the 16th bit has elapsed.
                            last_bit <= 1'b0;
                            bit_cnt  <= '0;
                            state    <= HOLD;
                        end else begin
                            // Rising edge: only the last eight samples survive in rx.
                            sclk_q <= 1'b1;
                            rx     <= {rx[SPI_DATA_W-2:0], bus.miso};
                        end
                    end
                end
                HOLD: begin
                    if (tick) begin
                        cs_n_q <= 1'b1;
                        done_q <= 1'b1;
                        if (rw_q == RW_READ) begin
                            rdata_q <= rx;
                        end
                        state <= DONE;
                    end
                end
                DONE: begin
                    done_q <= 1'b0;
                    busy_q <= 1'b0;
                    state  <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    assign bus.sclk  = sclk_q;
    assign bus.cs_n  = cs_n_q;
    assign bus.mosi  = mosi_q;
    assign bus.busy  = busy_q;
    assign bus.done  = done_q;
    assign bus.rdata = rdata_q;

endmodule

// File: tb/tb_spi_master.sv
// Bench for spi_master: random and directed transactions against an SPI memory model.
// Latency: n/a.
// Backpressure: host waits for busy=0 before each request.
module tb_spi_master;

    localparam int HALF = 4;
    localparam int FRAME_CYC = 34 * HALF;

    typedef struct {
        logic [15:0] bits;
        int          low;
        int          rises;
        int          gap;
    } frame_t;

    logic clk;
    logic reset_n;

    spi_master_if bus ();

    spi_master #(.HALF(HALF)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    int          n_vec = 0;
    int          n_err = 0;
    int          done_cnt = 0;
    int          sclk_idle_err = 0;
    frame_t      fq[$];
    logic [7:0]  slave_mem [128];
    logic [7:0]  model_mem [128];
    logic [7:0]  exp_rdata = 8'h00;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, got timeout required finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Memory-side pin model: records each frame and serves reads from slave_mem.
    initial begin : slave_model
        frame_t     cur;
        logic       in_frame;
        logic       prev_sclk;
        logic [7:0] cmd;
        int         falls;
        int         hi_cnt;
        in_frame  = 1'b0;
        prev_sclk = 1'b0;
        cmd       = 8'h00;
        falls     = 0;
        hi_cnt    = 0;
        cur       = '{bits: 16'h0, low: 0, rises: 0, gap: 0};
        bus.miso  = 1'b0;
        forever begin
            @(negedge clk);
            if (!reset_n) begin
                in_frame  = 1'b0;
                bus.miso  = 1'b0;
                prev_sclk = 1'b0;
                hi_cnt    = 0;
            end else begin
                if (bus.cs_n && bus.sclk) sclk_idle_err++;
                if (bus.done) done_cnt++;
                if (!bus.cs_n) begin
                    if (!in_frame) begin
                        in_frame = 1'b1;
                        cur      = '{bits: 16'h0, low: 0, rises: 0, gap: hi_cnt};
                        falls    = 0;
                        cmd      = 8'h00;
                    end
                    cur.low++;
                    if (bus.sclk && !prev_sclk) begin
                        cur.bits = {cur.bits[14:0], bus.mosi};
                        cur.rises++;
                        if (cur.rises == 8) cmd = cur.bits[7:0];
                    end
                    if (!bus.sclk && prev_sclk) begin
                        falls++;
                        if (cmd[0] && falls >= 8 && falls <= 15)
                            bus.miso = slave_mem[cmd[7:1]][15 - falls];
                        else
                            bus.miso = 1'b0;
                    end
                end else begin
                    if (in_frame) begin
                        if (cur.rises == 16 && !cmd[0]) slave_mem[cmd[7:1]] = cur.bits[7:0];
                        fq.push_back(cur);
                        in_frame = 1'b0;
                        hi_cnt   = 1;
                    end else begin
                        hi_cnt++;
                    end
                end
                prev_sclk = bus.sclk;
            end
        end
    end

    task automatic check_frame(input string tag, input logic [15:0] exp_bits);
        frame_t f;
        chk({tag, "_frames"}, fq.size(), 1);
        if (fq.size() > 0) begin
            f = fq.pop_front();
            chk({tag, "_bits"}, f.bits, exp_bits);
            chk({tag, "_cs_low"}, f.low, FRAME_CYC);
            chk({tag, "_rises"}, f.rises, 16);
        end
        fq.delete();
    endtask

    // One request; poke >= 0 pulses a conflicting start that many cycles into the frame.
    task automatic do_txn(input string tag, input logic r, input logic [6:0] a,
                          input logic [7:0] wd, input int poke);
        int          n;
        int          dc0;
        logic [15:0] exp_bits;
        logic [7:0]  exp_rd;
        n = 0;
        while (bus.busy && n < 1000) begin
            @(negedge clk);
            n++;
        end
        exp_bits = {a, r, r ? 8'h00 : wd};
        exp_rd   = r ? model_mem[a] : exp_rdata;
        if (!r) model_mem[a] = wd;
        dc0 = done_cnt;
        bus.start = 1'b1;
        bus.rw    = r;
        bus.addr  = a;
        bus.wdata = wd;
        @(negedge clk);
        chk({tag, "_busy_set"}, bus.busy, 1);
        n = 0;
        while (!bus.done && n < 40 * HALF) begin
            if (n == poke) begin
                bus.start = 1'b1;
                bus.rw    = ~r;
                bus.addr  = ~a;
                bus.wdata = ~wd;
            end else begin
                bus.start = 1'b0;
            end
            @(negedge clk);
            n++;
        end
        bus.start = 1'b0;
        chk({tag, "_done_seen"}, bus.done, 1);
        chk({tag, "_cs_at_done"}, bus.cs_n, 1);
        chk({tag, "_rdata"}, bus.rdata, exp_rd);
        exp_rdata = exp_rd;
        @(negedge clk);
        chk({tag, "_done_width"}, bus.done, 0);
        chk({tag, "_busy_clr"}, bus.busy, 0);
        chk({tag, "_done_cnt"}, done_cnt - dc0, 1);
        check_frame(tag, exp_bits);
    endtask

    initial begin : main
        logic       r;
        logic [6:0] a;
        logic [7:0] wd;
        int         n;
        int         dc0;
        int         seen;
        frame_t     f;

        reset_n   = 1'b0;
        bus.start = 1'b0;
        bus.rw    = 1'b0;
        bus.addr  = 7'h00;
        bus.wdata = 8'h00;
        for (int i = 0; i < 128; i++) begin
            wd = 8'($urandom);
            slave_mem[i] = wd;
            model_mem[i] = wd;
        end

        repeat (4) @(negedge clk);
        chk("rst_sclk", bus.sclk, 0);
        chk("rst_cs_n", bus.cs_n, 1);
        chk("rst_mosi", bus.mosi, 0);
        chk("rst_busy", bus.busy, 0);
        chk("rst_done", bus.done, 0);
        chk("rst_rdata", bus.rdata, 8'h00);
        reset_n = 1'b1;
        @(negedge clk);

        // Directed write then read at 7'h15.
        do_txn("wr15", 1'b0, 7'h15, 8'hA5, -1);
        slave_mem[7'h15] = 8'h3C;
        model_mem[7'h15] = 8'h3C;
        do_txn("rd15", 1'b1, 7'h15, 8'hFF, -1);

        // Loopback at the address extremes.
        do_txn("wr7f", 1'b0, 7'h7F, 8'hC3, -1);
        do_txn("wr00", 1'b0, 7'h00, 8'h5A, -1);
        do_txn("rd7f", 1'b1, 7'h7F, 8'h00, -1);
        do_txn("rd00", 1'b1, 7'h00, 8'h00, -1);
        do_txn("rd7f_b", 1'b1, 7'h7F, 8'h00, -1);

        // Conflicting start 50 cycles into a frame must be dropped.
        do_txn("poke", 1'b0, 7'h2B, 8'h96, 50);
        repeat (20) @(negedge clk);
        chk("poke_no_frame", fq.size(), 0);
        chk("poke_idle_cs", bus.cs_n, 1);

        // Reset 60 cycles into a read aborts the frame and clears rdata.
        dc0 = done_cnt;
        bus.start = 1'b1;
        bus.rw    = 1'b1;
        bus.addr  = 7'h7F;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (59) @(negedge clk);
        reset_n = 1'b0;
        @(negedge clk);
        chk("arst_cs_n", bus.cs_n, 1);
        chk("arst_sclk", bus.sclk, 0);
        chk("arst_busy", bus.busy, 0);
        chk("arst_rdata", bus.rdata, 8'h00);
        chk("arst_done", bus.done, 0);
        @(negedge clk);
        reset_n = 1'b1;
        chk("arst_no_done", done_cnt - dc0, 0);
        fq.delete();
        exp_rdata = 8'h00;
        @(negedge clk);
        do_txn("post_rst", 1'b1, 7'h7F, 8'h00, -1);

        // Back-to-back: start held high across three frames.
        fq.delete();
        seen = 0;
        n = 0;
        bus.start = 1'b1;
        bus.rw    = 1'b0;
        bus.addr  = 7'h33;
        bus.wdata = 8'h81;
        model_mem[7'h33] = 8'h81;
        while (seen < 3 && n < 4 * 40 * HALF) begin
            @(negedge clk);
            n++;
            if (bus.done) seen++;
        end
        bus.start = 1'b0;
        repeat (3) @(negedge clk);
        chk("b2b_dones", seen, 3);
        chk("b2b_frames", fq.size(), 3);
        for (int k = 0; k < 3; k++) begin
            if (fq.size() > 0) begin
                f = fq.pop_front();
                chk("b2b_bits", f.bits, 16'h6681);
                chk("b2b_cs_low", f.low, FRAME_CYC);
                if (k > 0) chk("b2b_gap", f.gap, 2);
            end
        end
        fq.delete();

        // Randomised traffic against the memory reference.
        for (int t = 0; t < 30; t++) begin
            r  = 1'($urandom_range(0, 1));
            a  = 7'($urandom_range(0, 127));
            wd = 8'($urandom);
            do_txn("rnd", r, a, wd, -1);
            repeat ($urandom_range(0, 3)) @(negedge clk);
        end

        chk("sclk_idle_low", sclk_idle_err, 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
